// File: rtl/uart_periph_pkg.sv
// Shared constants for the UART TX FIFO peripheral: register map, CTRL/STATUS
// bit positions, TX FSM states and parity modes.
package uart_periph_pkg;

   localparam logic [3:0] ADDR_STATUS = 4'h0;
   localparam logic [3:0] ADDR_DATA   = 4'h2;
   localparam logic [3:0] ADDR_CTRL   = 4'h4;
   localparam logic [3:0] ADDR_BAUD   = 4'h6;

   localparam int CTRL_LED     = 0;
   localparam int CTRL_TX_EN   = 1;
   localparam int CTRL_IRQ_EN  = 2;
   localparam int CTRL_CLR_OVF = 3;
   localparam int CTRL_FLUSH   = 4;

   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with one-cycle flush.
// A push while full is only accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && !flush && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/peripheral_uart_tx_fifo.sv
// J1 I/O-bus UART transmitter: register decode, read mux, TX FIFO and the
// serial framing FSM (start, data LSB first, optional parity, stop bits).
module peripheral_uart_tx_fifo
   import uart_periph_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int DEFAULT_DIV = 434,
   parameter int STOP_BITS   = 1,
   parameter int PARITY      = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] d_in,
   input  logic        cs,
   input  logic [3:0]  addr,
   input  logic        rd,
   input  logic        wr,
   output logic [15:0] d_out,
   output logic        tx,
   output logic        ledout,
   output logic        irq
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic              ctrl_led;
   logic              ctrl_tx_en;
   logic              ctrl_irq_en;
   logic              overflow;
   logic [15:0]       baud;
   logic [15:0]       rdata;

   logic              wr_en;
   logic              rd_en;
   logic              push;
   logic              ctrl_wr;
   logic              clr_ovf;
   logic              flush;
   logic              pop;
   logic [DATA_W-1:0] fifo_dout;
   logic              full;
   logic              empty;
   logic [LW-1:0]     level;
   logic [8:0]        lvl9;
   logic              busy;

   tx_state_e         state;
   tx_state_e         state_n;
   logic [15:0]       baud_cnt;
   logic [15:0]       baud_cnt_n;
   logic [15:0]       div_q;
   logic [15:0]       div_n;
   logic [3:0]        bit_cnt;
   logic [3:0]        bit_cnt_n;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_n;
   logic              par_q;
   logic              par_n;
   logic              tx_n;
   logic              start_ok;
   logic              load;
   logic              data_par;

   assign wr_en   = cs && wr;
   assign rd_en   = cs && rd;
   assign push    = wr_en && (addr == ADDR_DATA);
   assign ctrl_wr = wr_en && (addr == ADDR_CTRL);
   assign clr_ovf = ctrl_wr && d_in[CTRL_CLR_OVF];
   assign flush   = ctrl_wr && d_in[CTRL_FLUSH];

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (d_in[DATA_W-1:0]),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign lvl9   = 9'(level);
   assign busy   = (state != S_IDLE) || !empty;
   assign ledout = ctrl_led;
   assign irq    = empty && (state == S_IDLE) && ctrl_irq_en;

   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_STATUS: begin
            rdata[ST_BUSY]  = busy;
            rdata[ST_FULL]  = full;
            rdata[ST_EMPTY] = empty;
            rdata[ST_OVF]   = overflow;
            rdata[15:8]     = lvl9[8] ? 8'hFF : lvl9[7:0];
         end
         ADDR_CTRL: begin
            rdata[CTRL_LED]    = ctrl_led;
            rdata[CTRL_TX_EN]  = ctrl_tx_en;
            rdata[CTRL_IRQ_EN] = ctrl_irq_en;
         end
         ADDR_BAUD: rdata = baud;
         default:   rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_led    <= 1'b0;
         ctrl_tx_en  <= 1'b1;
         ctrl_irq_en <= 1'b0;
         baud        <= 16'(DEFAULT_DIV);
         overflow    <= 1'b0;
         d_out       <= '0;
      end else begin
         if (ctrl_wr) begin
            ctrl_led    <= d_in[CTRL_LED];
            ctrl_tx_en  <= d_in[CTRL_TX_EN];
            ctrl_irq_en <= d_in[CTRL_IRQ_EN];
         end
         if (wr_en && (addr == ADDR_BAUD)) baud <= (d_in == '0) ? 16'd1 : d_in;
         // a dropped push outranks a same-cycle clear
         if (push && full && !pop)         overflow <= 1'b1;
         else if (clr_ovf)                 overflow <= 1'b0;
         d_out <= rd_en ? rdata : '0;
      end
   end

   assign start_ok = ctrl_tx_en && !empty;
   assign data_par = ^fifo_dout;

   always_comb begin
      state_n    = state;
      baud_cnt_n = baud_cnt;
      div_n      = div_q;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      par_n      = par_q;
      tx_n       = tx;
      pop        = 1'b0;
      load       = 1'b0;
      unique case (state)
         S_IDLE: load = start_ok;
         S_START: begin
            if (baud_cnt == '0) begin
               state_n    = S_DATA;
               baud_cnt_n = div_q - 16'd1;
               bit_cnt_n  = '0;
               tx_n       = shreg[0];
               shreg_n    = shreg >> 1;
            end else begin
               baud_cnt_n = baud_cnt - 16'd1;
            end
         end
         S_DATA: begin
            if (baud_cnt == '0) begin
               baud_cnt_n = div_q - 16'd1;
               if (bit_cnt == 4'(DATA_W - 1)) begin
                  bit_cnt_n = '0;
                  if (PARITY != PARITY_NONE) begin
                     state_n = S_PAR;
                     tx_n    = par_q;
                  end else begin
                     state_n = S_STOP;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bit_cnt_n = bit_cnt + 4'd1;
                  tx_n      = shreg[0];
                  shreg_n   = shreg >> 1;
               end
            end else begin
               baud_cnt_n = baud_cnt - 16'd1;
            end
         end
         S_PAR: begin
            if (baud_cnt == '0) begin
               state_n    = S_STOP;
               baud_cnt_n = div_q - 16'd1;
               bit_cnt_n  = '0;
               tx_n       = 1'b1;
            end else begin
               baud_cnt_n = baud_cnt - 16'd1;
            end
         end
         S_STOP: begin
            if (baud_cnt == '0) begin
               if (bit_cnt == 4'(STOP_BITS - 1)) begin
                  if (start_ok) begin
                     load = 1'b1;
                  end else begin
                     state_n = S_IDLE;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bit_cnt_n  = bit_cnt + 4'd1;
                  baud_cnt_n = div_q - 16'd1;
               end
            end else begin
               baud_cnt_n = baud_cnt - 16'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // frame load is shared by IDLE and the stop-bit exit so frames chain gap-free
      if (load) begin
         pop        = 1'b1;
         state_n    = S_START;
         shreg_n    = fifo_dout;
         div_n      = baud;
         baud_cnt_n = baud - 16'd1;
         bit_cnt_n  = '0;
         par_n      = (PARITY == PARITY_ODD) ? ~data_par : data_par;
         tx_n       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         div_q    <= 16'd1;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_q    <= 1'b0;
         tx       <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         div_q    <= div_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         par_q    <= par_n;
         tx       <= tx_n;
      end
   end

endmodule

// File: tb/tb_peripheral_uart_tx_fifo.sv
// Bench for peripheral_uart_tx_fifo: register table plus serial-frame scoreboard
// on a default instance and a 7-bit / odd-parity / 2-stop instance.
`timescale 1ns/1ps
module tb_peripheral_uart_tx_fifo;
   import uart_periph_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] d_in = '0;
   logic        cs1 = 1'b0;
   logic        cs2 = 1'b0;
   logic [3:0]  addr = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [15:0] d_out1, d_out2;
   logic        tx1, tx2, led1, led2, irq1, irq2;

   always #5 clk = ~clk;

   peripheral_uart_tx_fifo dut (
      .clk(clk), .rst(rst), .d_in(d_in), .cs(cs1), .addr(addr), .rd(rd), .wr(wr),
      .d_out(d_out1), .tx(tx1), .ledout(led1), .irq(irq1)
   );

   peripheral_uart_tx_fifo #(
      .DATA_W(7), .FIFO_DEPTH(4), .DEFAULT_DIV(434), .STOP_BITS(2), .PARITY(2)
   ) dut2 (
      .clk(clk), .rst(rst), .d_in(d_in), .cs(cs2), .addr(addr), .rd(rd), .wr(wr),
      .d_out(d_out2), .tx(tx2), .ledout(led2), .irq(irq2)
   );

   int checks = 0;
   int errors = 0;
   bit exp_q1[$];
   bit exp_q2[$];
   logic [15:0] rd_q[$];

   typedef struct {
      bit          is_wr;
      int          sel;
      logic [3:0]  a;
      logic [15:0] data;
      string       name;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
      end
   endtask

   task automatic bus_wr(input int sel, input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      cs1 = (sel == 1); cs2 = (sel == 2); wr = 1'b1; addr = a; d_in = d;
      @(negedge clk);
      cs1 = 1'b0; cs2 = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_rd(input int sel, input logic [3:0] a, input logic [15:0] exp, input string nm);
      @(negedge clk);
      cs1 = (sel == 1); cs2 = (sel == 2); rd = 1'b1; addr = a;
      rd_q.push_back(exp);
      @(posedge clk); #1;
      check(nm, (sel == 2) ? d_out2 : d_out1, rd_q.pop_front());
      @(negedge clk);
      cs1 = 1'b0; cs2 = 1'b0; rd = 1'b0;
      @(posedge clk); #1;
      check({nm, "_idle"}, (sel == 2) ? d_out2 : d_out1, 16'h0000);
   endtask

   task automatic qpush(input int sel, input bit b);
      if (sel == 2) exp_q2.push_back(b);
      else          exp_q1.push_back(b);
   endtask

   // Queue the expected line levels of one frame, then push the byte.
   task automatic push_frame(input int sel, input logic [15:0] data, input int nbits,
                             input int par, input int stops);
      int ones = 0;
      qpush(sel, 1'b0);
      for (int i = 0; i < nbits; i++) begin
         qpush(sel, data[i]);
         ones += int'(data[i]);
      end
      if (par == PARITY_EVEN) qpush(sel, (ones % 2) == 1);
      if (par == PARITY_ODD)  qpush(sel, (ones % 2) == 0);
      for (int i = 0; i < stops; i++) qpush(sel, 1'b1);
      bus_wr(sel, ADDR_DATA, data);
   endtask

   // Wait for a start bit, then check the line every clock for nbits bit times.
   task automatic rx_check(input int sel, input int div, input int nbits, input bit chk_irq,
                           input string nm);
      int   t = 0;
      logic cur;
      bit   b;
      cur = (sel == 2) ? tx2 : tx1;
      while (cur !== 1'b0 && t < 200) begin
         @(posedge clk); #1;
         t++;
         cur = (sel == 2) ? tx2 : tx1;
      end
      if (cur !== 1'b0) begin
         check({nm, "_start_timeout"}, {15'b0, cur}, 16'h0000);
         if (sel == 2) exp_q2.delete(); else exp_q1.delete();
         return;
      end
      for (int i = 0; i < nbits; i++) begin
         if (sel == 2) b = exp_q2.pop_front();
         else          b = exp_q1.pop_front();
         for (int c = 0; c < div; c++) begin
            cur = (sel == 2) ? tx2 : tx1;
            check($sformatf("%s_bit%0d_clk%0d", nm, i, c), {15'b0, cur}, {15'b0, b});
            if (chk_irq) check($sformatf("%s_irq_low_bit%0d", nm, i), {15'b0, irq2}, 16'h0000);
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs.push_back('{0, 1, ADDR_STATUS, 16'h0004, "rst_status"});
      vecs.push_back('{0, 1, ADDR_BAUD,   16'h01B2, "rst_baud"});
      vecs.push_back('{0, 1, ADDR_CTRL,   16'h0002, "rst_ctrl"});
      vecs.push_back('{0, 2, ADDR_STATUS, 16'h0004, "rst_status2"});
      vecs.push_back('{0, 2, ADDR_BAUD,   16'h01B2, "rst_baud2"});
      vecs.push_back('{0, 1, ADDR_DATA,   16'h0000, "data_reads_zero"});
      vecs.push_back('{0, 1, 4'h1,        16'h0000, "unmapped_read"});
      vecs.push_back('{1, 1, ADDR_BAUD,   16'h0000, ""});
      vecs.push_back('{0, 1, ADDR_BAUD,   16'h0001, "baud_zero_as_one"});
      vecs.push_back('{1, 1, ADDR_BAUD,   16'h1234, ""});
      vecs.push_back('{0, 1, ADDR_BAUD,   16'h1234, "baud_rw"});
      vecs.push_back('{1, 1, ADDR_CTRL,   16'h001F, ""});
      vecs.push_back('{0, 1, ADDR_CTRL,   16'h0007, "ctrl_pulse_bits_read_zero"});
      vecs.push_back('{1, 1, ADDR_CTRL,   16'h0002, ""});
      vecs.push_back('{0, 1, ADDR_CTRL,   16'h0002, "ctrl_rw"});
      vecs.push_back('{1, 1, 4'h8,        16'hFFFF, ""});
      vecs.push_back('{0, 1, ADDR_CTRL,   16'h0002, "unmapped_wr_ctrl"});
      vecs.push_back('{0, 1, ADDR_BAUD,   16'h1234, "unmapped_wr_baud"});

      repeat (3) @(negedge clk);
      check("rst_tx", {15'b0, tx1}, 16'h0001);
      check("rst_irq", {15'b0, irq1}, 16'h0000);
      check("rst_led", {15'b0, led1}, 16'h0000);
      check("rst_dout", d_out1, 16'h0000);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].is_wr) bus_wr(vecs[i].sel, vecs[i].a, vecs[i].data);
         else               bus_rd(vecs[i].sel, vecs[i].a, vecs[i].data, vecs[i].name);
      end

      bus_wr(1, ADDR_CTRL, 16'h0003);
      check("ledout_on", {15'b0, led1}, 16'h0001);
      bus_wr(1, ADDR_CTRL, 16'h0002);
      check("ledout_off", {15'b0, led1}, 16'h0000);

      // single 0x55 frame, divisor 4
      bus_wr(1, ADDR_BAUD, 16'd4);
      fork
         push_frame(1, 16'h0055, 8, PARITY_NONE, 1);
         rx_check(1, 4, 10, 1'b0, "f55");
         begin
            repeat (12) @(negedge clk);
            bus_rd(1, ADDR_STATUS, 16'h0005, "busy_mid_frame");
         end
      join
      bus_rd(1, ADDR_STATUS, 16'h0004, "busy_after_frame");

      // back-to-back frames must chain without an idle clock
      bus_wr(1, ADDR_BAUD, 16'd2);
      fork
         begin
            push_frame(1, 16'h00A1, 8, PARITY_NONE, 1);
            push_frame(1, 16'h00A2, 8, PARITY_NONE, 1);
         end
         rx_check(1, 2, 20, 1'b0, "b2b");
      join
      check("b2b_idle_tx", {15'b0, tx1}, 16'h0001);

      // overflow with transmitter disabled
      bus_wr(1, ADDR_CTRL, 16'h0000);
      for (int i = 0; i < 17; i++) bus_wr(1, ADDR_DATA, 16'(i));
      bus_rd(1, ADDR_STATUS, 16'h100B, "overflow_full");
      check("ovf_tx_idle", {15'b0, tx1}, 16'h0001);
      bus_wr(1, ADDR_CTRL, 16'h0008);
      bus_rd(1, ADDR_STATUS, 16'h1003, "clr_ovf_keeps_level");
      bus_rd(1, ADDR_CTRL, 16'h0000, "ctrl_after_clr");
      bus_wr(1, ADDR_CTRL, 16'h0010);
      bus_rd(1, ADDR_STATUS, 16'h0004, "flush_empties");
      bus_wr(1, ADDR_CTRL, 16'h0002);
      repeat (3) @(posedge clk); #1;
      check("flush_no_tx", {15'b0, tx1}, 16'h0001);

      // 7-bit, odd parity, two stop bits; irq only once the frame has ended
      bus_wr(2, ADDR_BAUD, 16'd3);
      bus_wr(2, ADDR_CTRL, 16'h0006);
      check("irq2_idle_high", {15'b0, irq2}, 16'h0001);
      fork
         push_frame(2, 16'h0003, 7, PARITY_ODD, 2);
         rx_check(2, 3, 11, 1'b1, "par");
      join
      check("irq2_after_stop", {15'b0, irq2}, 16'h0001);
      check("par_tx_idle", {15'b0, tx2}, 16'h0001);

      // asynchronous reset in the middle of a data bit
      bus_wr(1, ADDR_BAUD, 16'd4);
      bus_wr(1, ADDR_DATA, 16'h0000);
      repeat (6) @(posedge clk);
      #2;
      check("pre_reset_tx_data0", {15'b0, tx1}, 16'h0000);
      rst = 1'b0;
      #1;
      check("async_reset_tx", {15'b0, tx1}, 16'h0001);
      @(negedge clk);
      rst = 1'b1;
      bus_rd(1, ADDR_STATUS, 16'h0004, "post_reset_status");
      bus_rd(1, ADDR_CTRL, 16'h0002, "post_reset_ctrl");
      bus_rd(1, ADDR_BAUD, 16'h01B2, "post_reset_baud");
      check("post_reset_tx", {15'b0, tx1}, 16'h0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
